// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rf_wb_arbiter
//  Brief    : Register-file write-port arbiter, ALU priority over buffered loads.
//             Optional load bypass via RF_WB_BYPASS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    input  logic [ADDR_W-1:0]      alu_rd,
    input  logic [DATA_W-1:0]      alu_data,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [ADDR_W-1:0]      mem_rd,
    input  logic [DATA_W-1:0]      mem_data,
    output logic                   rf_we,
    output logic [ADDR_W-1:0]      rf_rd,
    output logic [DATA_W-1:0]      rf_data,
    output logic [2**ADDR_W-1:0]   pending_mask
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] r_fifo_rd   [DEPTH];
    logic [DATA_W-1:0] r_fifo_data [DEPTH];
    logic [DEPTH-1:0]  r_fifo_live;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_accept;
    logic              w_empty;
    logic              w_pop;
    logic              w_head_live;
    logic              w_bypass;
    logic              w_push;
    logic              w_push_live;
    logic [DEPTH-1:0]  w_squash;

    assign mem_ready   = !rst && (r_count < c_depth);
    assign w_accept    = mem_valid && mem_ready;
    assign w_empty     = (r_count == '0);
    assign w_pop       = !alu_valid && !w_empty;
    assign w_head_live = r_fifo_live[r_rd_ptr];

`ifdef RF_WB_BYPASS_EN
    assign w_bypass    = w_accept && !alu_valid && w_empty && (mem_rd != '0);
`else
    assign w_bypass    = 1'b0;
`endif

    assign w_push      = w_accept && (mem_rd != '0) && !w_bypass;
    // A same-cycle ALU write to the same register is program-younger.
    assign w_push_live = !(alu_valid && (alu_rd == mem_rd));

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_squash
            assign w_squash[gi] = alu_valid && r_fifo_live[gi] && (r_fifo_rd[gi] == alu_rd);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_fifo_live <= '0;
        end else begin
            r_fifo_live <= r_fifo_live & ~w_squash;
            if (w_pop) begin
                r_fifo_live[r_rd_ptr] <= 1'b0;
                r_rd_ptr              <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_fifo_live[r_wr_ptr] <= w_push_live;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; liveness alone decides visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= mem_rd;
            r_fifo_data[r_wr_ptr] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we   <= 1'b0;
            rf_rd   <= '0;
            rf_data <= '0;
        end else if (alu_valid && (alu_rd != '0)) begin
            rf_we   <= 1'b1;
            rf_rd   <= alu_rd;
            rf_data <= alu_data;
        end else if (w_pop && w_head_live) begin
            rf_we   <= 1'b1;
            rf_rd   <= r_fifo_rd[r_rd_ptr];
            rf_data <= r_fifo_data[r_rd_ptr];
        end else if (w_bypass) begin
            rf_we   <= 1'b1;
            rf_rd   <= mem_rd;
            rf_data <= mem_data;
        end else begin
            rf_we   <= 1'b0;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_fifo_live[i]) begin
                pending_mask[r_fifo_rd[i]] = 1'b1;
            end
        end
        pending_mask[0] = 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf_wb_arbiter
//  Brief    : Scoreboard bench for rf_wb_arbiter against a queue-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 2;
    localparam int NREG   = 2**ADDR_W;
    localparam time PERIOD = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              alu_valid = 1'b0;
    logic [ADDR_W-1:0] alu_rd = '0;
    logic [DATA_W-1:0] alu_data = '0;
    logic              mem_valid = 1'b0;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rd = '0;
    logic [DATA_W-1:0] mem_data = '0;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_data;
    logic [NREG-1:0]   pending_mask;

    rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .rf_we        (rf_we),
        .rf_rd        (rf_rd),
        .rf_data      (rf_data),
        .pending_mask (pending_mask)
    );

    always #(PERIOD/2) clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
        bit                live;
    } ent_t;

    typedef struct {
        time               t;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wr_t;

    ent_t q[$];     // model of the load buffer, oldest first
    wr_t  wq[$];    // expected register-file writes, in time order
    int   checks   = 0;
    int   failures = 0;
    bit   model_ok = 1'b0;
    bit   prev_rst = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NREG-1:0] model_mask();
        logic [NREG-1:0] m = '0;
        foreach (q[i]) if (q[i].live) m[q[i].rd] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    // Monitor: every write the DUT presents must match the oldest expectation.
    always @(negedge clk) begin
        while (wq.size() > 0 && wq[0].t < $time) begin
            chk("missed_write_rd", 32'hFFFF_FFFF, 32'(wq[0].rd));
            void'(wq.pop_front());
        end
        if (rf_we === 1'b1) begin
            if (wq.size() > 0 && wq[0].t == $time) begin
                chk("write_rd", 32'(rf_rd), 32'(wq[0].rd));
                chk("write_data", 32'(rf_data), 32'(wq[0].data));
                void'(wq.pop_front());
            end else begin
                chk("unexpected_write", 32'(rf_rd), 32'hFFFF_FFFF);
            end
        end else if (wq.size() > 0 && wq[0].t == $time) begin
            chk("write_missing_we", 32'(rf_we), 32'd1);
            void'(wq.pop_front());
        end
    end

    task automatic step(input bit t_rst, input bit t_av, input logic [ADDR_W-1:0] t_ard,
                        input logic [DATA_W-1:0] t_ad, input bit t_mv,
                        input logic [ADDR_W-1:0] t_mrd, input logic [DATA_W-1:0] t_md);
        time  tn;
        bit   ready;
        bit   was_empty;
        ent_t e;
        wr_t  w;
        @(negedge clk);
        tn = $time;
        if (model_ok) begin
            chk("pending_mask", 32'(pending_mask), 32'(model_mask()));
            if (prev_rst) begin
                chk("reset_rf_rd", 32'(rf_rd), 32'd0);
                chk("reset_rf_data", 32'(rf_data), 32'd0);
            end
        end
        rst = t_rst; alu_valid = t_av; alu_rd = t_ard; alu_data = t_ad;
        mem_valid = t_mv; mem_rd = t_mrd; mem_data = t_md;
        #1;
        ready = !t_rst && (q.size() < DEPTH);
        if (model_ok || t_rst) chk("mem_ready", 32'(mem_ready), 32'(ready));

        if (t_rst) begin
            q.delete();
            model_ok = 1'b1;
            prev_rst = 1'b1;
        end else begin
            prev_rst  = 1'b0;
            was_empty = (q.size() == 0);
            if (t_av) begin
                for (int i = 0; i < q.size(); i++) begin
                    if (q[i].rd == t_ard) begin
                        e = q[i]; e.live = 1'b0; q[i] = e;
                    end
                end
                if (t_ard != '0) begin
                    w.t = tn + PERIOD; w.rd = t_ard; w.data = t_ad; wq.push_back(w);
                end
            end else if (!was_empty) begin
                e = q.pop_front();
                if (e.live) begin
                    w.t = tn + PERIOD; w.rd = e.rd; w.data = e.data; wq.push_back(w);
                end
            end
            if (t_mv && ready && t_mrd != '0) begin
`ifdef RF_WB_BYPASS_EN
                if (!t_av && was_empty) begin
                    w.t = tn + PERIOD; w.rd = t_mrd; w.data = t_md; wq.push_back(w);
                end else begin
                    e.rd = t_mrd; e.data = t_md; e.live = !(t_av && t_ard == t_mrd);
                    q.push_back(e);
                end
`else
                e.rd = t_mrd; e.data = t_md; e.live = !(t_av && t_ard == t_mrd);
                q.push_back(e);
`endif
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        idle(1);
        // single ALU write
        step(1'b0, 1'b1, 3'd3, 16'h1234, 1'b0, '0, '0);
        idle(2);
        // single load with idle ALU
        step(1'b0, 1'b0, '0, '0, 1'b1, 3'd5, 16'hBEEF);
        idle(3);
        // ALU busy 4 cycles fills the buffer, then drains in order
        step(1'b0, 1'b1, 3'd6, 16'h0A0A, 1'b1, 3'd1, 16'h1111);
        step(1'b0, 1'b1, 3'd6, 16'h0B0B, 1'b1, 3'd2, 16'h2222);
        step(1'b0, 1'b1, 3'd6, 16'h0C0C, 1'b1, 3'd7, 16'h7777);
        step(1'b0, 1'b1, 3'd6, 16'h0D0D, 1'b0, '0, '0);
        idle(4);
        // buffered load squashed by a younger ALU write
        step(1'b0, 1'b1, 3'd6, 16'h0E0E, 1'b1, 3'd4, 16'h4444);
        step(1'b0, 1'b1, 3'd4, 16'h0001, 1'b0, '0, '0);
        idle(3);
        // same-cycle collision enqueued dead
        step(1'b0, 1'b1, 3'd2, 16'h5A5A, 1'b1, 3'd2, 16'hA5A5);
        idle(3);
        // r0 targets never write
        step(1'b0, 1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 16'hFFFF);
        step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 16'h1234);
        idle(2);
        // reset discards two buffered loads
        step(1'b0, 1'b1, 3'd6, 16'h0101, 1'b1, 3'd3, 16'h3333);
        step(1'b0, 1'b1, 3'd7, 16'h0202, 1'b1, 3'd5, 16'h5555);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        idle(4);
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 1) == 1,
                 ADDR_W'($urandom_range(0, NREG-1)),
                 DATA_W'($urandom),
                 $urandom_range(0, 4) < 3,
                 ADDR_W'($urandom_range(0, NREG-1)),
                 DATA_W'($urandom));
        end
        idle(DEPTH + 4);
        chk("drained_expectations", 32'(wq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
